ro_buffer: RTL

RO_BUFFER -- requirements
Module: ro_buffer

---
 rtl/ro_buffer_pkg.sv | 17 +
 rtl/ro_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ro_buffer_pkg.sv
// rtl/ro_buffer_pkg.sv - shared sizes and types for the reorder buffer
package ro_buffer_pkg;

  localparam int RO_BUFFER_SIZE = 16;
  localparam int RO_ID_W        = $clog2(RO_BUFFER_SIZE) + 1;

  typedef logic [RO_ID_W-1:0] RO_BUFFER_ID_TYPE;
  typedef logic [4:0]         REG_ID_TYPE;
  typedef logic [31:0]        REG_TYPE;
  typedef logic [31:0]        ADDR_TYPE;

  typedef struct packed {
    logic    ready;
    REG_TYPE value;
  } lookup_t;

endpackage

// File: rtl/ro_buffer.sv
// rtl/ro_buffer.sv - in-order commit reorder buffer with operand lookup and flush on mispredict
module ro_buffer
  import ro_buffer_pkg::*;
#(
  parameter int RO_BUFFER_SIZE = ro_buffer_pkg::RO_BUFFER_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid_from_issuer,
  input  REG_ID_TYPE       rd_from_issuer,
  input  logic             is_branch_from_issuer,
  input  logic             predicted_taken_from_issuer,
  output RO_BUFFER_ID_TYPE dest_to_issuer,
  output logic             full_to_issuer,
  input  RO_BUFFER_ID_TYPE query_j_from_issuer,
  input  RO_BUFFER_ID_TYPE query_k_from_issuer,
  output logic             ready_j_to_issuer,
  output REG_TYPE          value_j_to_issuer,
  output logic             ready_k_to_issuer,
  output REG_TYPE          value_k_to_issuer,
  input  logic             wb_valid_from_cdb,
  input  RO_BUFFER_ID_TYPE wb_dest_from_cdb,
  input  REG_TYPE          wb_value_from_cdb,
  input  logic             wb_taken_from_cdb,
  input  ADDR_TYPE         wb_target_from_cdb,
  output RO_BUFFER_ID_TYPE dest_to_reg_file,
  output REG_ID_TYPE       rd_to_reg_file,
  output REG_TYPE          value_to_reg_file,
  output logic             reset_to_rob_bus,
  output ADDR_TYPE         pc_to_fetcher
);

  localparam int IDX_W = $clog2(RO_BUFFER_SIZE);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   count_t;

  logic [RO_BUFFER_SIZE-1:0] busy_q, ready_q;
  REG_ID_TYPE                rd_q        [RO_BUFFER_SIZE];
  REG_TYPE                   value_q     [RO_BUFFER_SIZE];
  logic                      is_branch_q [RO_BUFFER_SIZE];
  logic                      pred_q      [RO_BUFFER_SIZE];
  logic                      taken_q     [RO_BUFFER_SIZE];
  ADDR_TYPE                  target_q    [RO_BUFFER_SIZE];

  idx_t   head_q, head_d, tail_q, tail_d, wb_idx;
  count_t count_q, count_d;
  logic   issue_fire, head_done, mispredict, wb_fire;
  lookup_t look_j, look_k;

  RO_BUFFER_ID_TYPE commit_dest_q;
  REG_ID_TYPE       commit_rd_q;
  REG_TYPE          commit_value_q;
  logic             flush_q;
  ADDR_TYPE         flush_pc_q;

  function automatic idx_t id_to_idx(RO_BUFFER_ID_TYPE id);
    return idx_t'(id - RO_BUFFER_ID_TYPE'(1));
  endfunction

  function automatic RO_BUFFER_ID_TYPE idx_to_id(idx_t idx);
    return RO_BUFFER_ID_TYPE'(idx) + RO_BUFFER_ID_TYPE'(1);
  endfunction

  function automatic logic id_in_range(RO_BUFFER_ID_TYPE id);
    return (id != '0) && (int'(id) <= RO_BUFFER_SIZE);
  endfunction

  // Stored result wins; otherwise a same-cycle CDB broadcast is forwarded.
  function automatic lookup_t lookup(RO_BUFFER_ID_TYPE q);
    lookup_t r;
    r = '0;
    if (id_in_range(q)) begin
      if (busy_q[id_to_idx(q)] && ready_q[id_to_idx(q)]) begin
        r.ready = 1'b1;
        r.value = value_q[id_to_idx(q)];
      end else if (wb_valid_from_cdb && wb_dest_from_cdb == q) begin
        r.ready = 1'b1;
        r.value = wb_value_from_cdb;
      end
    end
    return r;
  endfunction

  always_comb begin
    look_j = lookup(query_j_from_issuer);
    look_k = lookup(query_k_from_issuer);
  end

  assign ready_j_to_issuer = look_j.ready;
  assign value_j_to_issuer = look_j.value;
  assign ready_k_to_issuer = look_k.ready;
  assign value_k_to_issuer = look_k.value;

  assign full_to_issuer = (count_q == count_t'(RO_BUFFER_SIZE));
  assign dest_to_issuer = idx_to_id(tail_q);

  always_comb begin
    issue_fire = issue_valid_from_issuer && !full_to_issuer;
    head_done  = busy_q[head_q] && ready_q[head_q];
    mispredict = head_done && is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    wb_idx     = id_to_idx(wb_dest_from_cdb);
    wb_fire    = wb_valid_from_cdb && id_in_range(wb_dest_from_cdb) && busy_q[wb_idx];

    head_d  = head_done  ? head_q + idx_t'(1) : head_q;
    tail_d  = issue_fire ? tail_q + idx_t'(1) : tail_q;
    count_d = count_q;
    if (issue_fire && !head_done) count_d = count_q + count_t'(1);
    if (!issue_fire && head_done) count_d = count_q - count_t'(1);
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_dest_q  <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_dest_q  <= (head_done && rd_q[head_q] != '0) ? idx_to_id(head_q) : '0;
      commit_rd_q    <= head_done ? rd_q[head_q] : '0;
      commit_value_q <= head_done ? value_q[head_q] : '0;
      flush_q        <= mispredict;
      flush_pc_q     <= mispredict ? target_q[head_q] : '0;
      if (mispredict) begin
        busy_q <= '0;
      end else begin
        if (head_done) busy_q[head_q] <= 1'b0;
        if (issue_fire) begin
          busy_q[tail_q]      <= 1'b1;
          ready_q[tail_q]     <= 1'b0;
          rd_q[tail_q]        <= rd_from_issuer;
          is_branch_q[tail_q] <= is_branch_from_issuer;
          pred_q[tail_q]      <= predicted_taken_from_issuer;
        end
        if (wb_fire) begin
          ready_q[wb_idx]  <= 1'b1;
          value_q[wb_idx]  <= wb_value_from_cdb;
          taken_q[wb_idx]  <= wb_taken_from_cdb;
          target_q[wb_idx] <= wb_target_from_cdb;
        end
      end
    end
  end

  assign dest_to_reg_file  = commit_dest_q;
  assign rd_to_reg_file    = commit_rd_q;
  assign value_to_reg_file = commit_value_q;
  assign reset_to_rob_bus  = flush_q;
  assign pc_to_fetcher     = flush_pc_q;

endmodule
